// File: rtl/tk3_lfsr_rewind.sv
// Rewinds a 128-bit TK3 tweakey state by n steps of the per-byte TK3 LFSR.
// Each byte is stepped backwards independently, STEPS_PER_CYCLE steps per RUN cycle.
module tk3_lfsr_rewind #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [5:0]   in_steps,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] GROUP = 6'(STEPS_PER_CYCLE);

   logic [1:0]   state;
   logic [5:0]   rem;
   logic [127:0] data_q;
   logic [5:0]   grp;
   logic [127:0] stepped;

   // Inverse of x -> {x[0]^x[6], x[7:1]}: the bit shifted out on the forward
   // step is recovered from the new top bit and the old bit 6 (now bit 5).
   function automatic logic [7:0] inv_byte(input logic [7:0] y);
      return {y[6:0], y[7] ^ y[5]};
   endfunction

   function automatic logic [127:0] inv_block(input logic [127:0] d);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[8*k +: 8] = inv_byte(d[8*k +: 8]);
      end
      return r;
   endfunction

   // The final group of a job may be partial; clamp so rem never underflows.
   assign grp = (rem < GROUP) ? rem : GROUP;

   // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      stepped = data_q;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         if (6'(i) < grp) begin
            stepped = inv_block(stepped);
         end
      end
   end

   // NOTE: state registers update with non-blocking assignments only; reset is synchronous and wins over any handshake.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         rem    <= '0;
         data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  data_q <= in_data;
                  rem    <= in_steps;
                  state  <= (in_steps != 6'd0) ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               data_q <= stepped;
               rem    <= rem - grp;
               if (rem == grp) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign out_data  = data_q;

endmodule

// File: tb/tb_tk3_lfsr_rewind.sv
// Directed bench: runs a P=1 and a P=4 instance side by side on shared inputs
// and checks results against hand values or a forward-LFSR replay.
module tb_tk3_lfsr_rewind;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [127:0] in_data;
   logic [5:0]   in_steps;
   logic         out_ready;

   logic         in_ready1, out_valid1, busy1;
   logic [127:0] out_data1;
   logic         in_ready4, out_valid4, busy4;
   logic [127:0] out_data4;

   int total = 0;
   int bad   = 0;

   tk3_lfsr_rewind #(.STEPS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_steps(in_steps),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
   );

   tk3_lfsr_rewind #(.STEPS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_steps(in_steps),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] data;
      logic [5:0]   steps;
      logic [127:0] exp;
      bit           exact;
      int           lat1;
      int           lat4;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Forward TK3 LFSR, used to undo the DUT's rewind.
   function automatic logic [127:0] fwd(input logic [127:0] d, input int n);
      logic [127:0] r;
      r = d;
      for (int s = 0; s < n; s++) begin
         for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = {r[8*k] ^ r[8*k+6], r[8*k+7 -: 7]};
         end
      end
      return r;
   endfunction

   // Called at a negedge right after the acceptance edge; counts edges until out_valid.
   task automatic wait_done(output int l1, output int l4);
      l1 = -1;
      l4 = -1;
      for (int c = 0; c <= 100; c++) begin
         if (out_valid1 && l1 < 0) l1 = c;
         if (out_valid4 && l4 < 0) l4 = c;
         if (l1 >= 0 && l4 >= 0) break;
         @(negedge clk);
      end
   endtask

   task automatic accept(input logic [127:0] d, input logic [5:0] n, input string name);
      @(negedge clk);
      check({name, "_in_ready1"}, 128'(in_ready1), 128'(1));
      check({name, "_in_ready4"}, 128'(in_ready4), 128'(1));
      in_valid = 1'b1;
      in_data  = d;
      in_steps = n;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      in_steps = ~n;
   endtask

   task automatic check_result(input vec_t v, input logic [127:0] o1, input logic [127:0] o4);
      if (v.exact) begin
         check({v.name, "_data1"}, o1, v.exp);
         check({v.name, "_data4"}, o4, v.exp);
      end else begin
         check({v.name, "_fwd1"}, fwd(o1, int'(v.steps)), v.data);
         check({v.name, "_fwd4"}, fwd(o4, int'(v.steps)), v.data);
      end
   endtask

   task automatic run_job(input vec_t v);
      int l1, l4;
      accept(v.data, v.steps, v.name);
      wait_done(l1, l4);
      check({v.name, "_lat1"}, 128'(l1), 128'(v.lat1));
      check({v.name, "_lat4"}, 128'(l4), 128'(v.lat4));
      check_result(v, out_data1, out_data4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({v.name, "_idle_ready1"}, 128'({in_ready1, out_valid1, busy1}), 128'(3'b100));
      check({v.name, "_idle_ready4"}, 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
   endtask

   initial begin
      int l1, l4;
      logic [127:0] snap1, snap4;
      vec_t hv;

      vecs[0] = '{"ones_n1",  {16{8'h01}},        6'd1,  {16{8'h02}},        1'b1, 1,  1};
      vecs[1] = '{"alt_n1",   {8{8'h20, 8'h80}},  6'd1,  {8{8'h41, 8'h01}},  1'b1, 1,  1};
      vecs[2] = '{"rand_n0",  128'h0,             6'd0,  128'h0,             1'b1, 0,  0};
      vecs[3] = '{"rand_n20", 128'h0,             6'd20, 128'h0,             1'b0, 20, 5};
      vecs[4] = '{"rand_n63", 128'h0,             6'd63, 128'h0,             1'b0, 63, 16};
      vecs[5] = '{"rand_n2",  128'h0,             6'd2,  128'h0,             1'b0, 2,  1};
      vecs[6] = '{"rand_n5",  128'h0,             6'd5,  128'h0,             1'b0, 5,  2};
      for (int i = 2; i < 7; i++) begin
         vecs[i].data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      vecs[2].exp = vecs[2].data;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_steps  = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl1", 128'({in_ready1, out_valid1, busy1}), 128'(3'b100));
      check("reset_ctl4", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
      check("reset_data1", out_data1, 128'h0);
      check("reset_data4", out_data4, 128'h0);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_job(vecs[i]);
      end

      // Consumer stalls 10 cycles in DONE while new jobs are offered.
      hv = '{"hold", {$urandom(), $urandom(), $urandom(), $urandom()}, 6'd3, 128'h0, 1'b0, 3, 1};
      accept(hv.data, hv.steps, hv.name);
      wait_done(l1, l4);
      check("hold_lat1", 128'(l1), 128'(3));
      check("hold_lat4", 128'(l4), 128'(1));
      snap1 = out_data1;
      snap4 = out_data4;
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_steps = 6'd0;
         @(negedge clk);
         check("hold_ctl1", 128'({in_ready1, out_valid1}), 128'(2'b01));
         check("hold_ctl4", 128'({in_ready4, out_valid4}), 128'(2'b01));
         check("hold_data1", out_data1, snap1);
         check("hold_data4", out_data4, snap4);
      end
      check_result(hv, snap1, snap4);
      // in_valid stays high across the handoff edge and must not be taken.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("handoff_ctl1", 128'({in_ready1, out_valid1, busy1}), 128'(3'b100));
      check("handoff_ctl4", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
      @(negedge clk);
      check("handoff_noaccept1", 128'({in_ready1, busy1}), 128'(2'b10));
      check("handoff_noaccept4", 128'({in_ready4, busy4}), 128'(2'b10));

      // Reset arrives in the middle of a long job.
      accept({$urandom(), $urandom(), $urandom(), $urandom()}, 6'd40, "abort");
      repeat (6) @(negedge clk);
      check("abort_busy1", 128'({busy1, out_valid1}), 128'(2'b10));
      check("abort_busy4", 128'({busy4, out_valid4}), 128'(2'b10));
      rst       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("abort_ctl1", 128'({in_ready1, out_valid1, busy1}), 128'(3'b100));
      check("abort_ctl4", 128'({in_ready4, out_valid4, busy4}), 128'(3'b100));
      check("abort_data1", out_data1, 128'h0);
      check("abort_data4", out_data4, 128'h0);
      vecs[3].name = "after_abort";
      run_job(vecs[3]);
      run_job(vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
